// File: rtl/rob_pkg.sv
// Shared ROB definitions: tag width, depth and the tag-increment rule.
// Latency: n/a (constants and one pure function).
// Backpressure: n/a.
// Ports: none. Holds `ROB_ENTRY_WIDTH (default 3), ROB_DEPTH = 2^W-1 and
// tag_inc(), which steps 1,2,..,max,1 so tag 0 ("no tag / ready") is never issued.
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 3
`endif

package rob_pkg;
    localparam int TAG_W     = `ROB_ENTRY_WIDTH;
    localparam int ROB_SLOTS = 1 << TAG_W;      // index 0 reserved, never allocated
    localparam int ROB_DEPTH = ROB_SLOTS - 1;   // usable entries

    typedef logic [TAG_W-1:0] tag_t;

    // Wrap from the top tag straight to 1; 0 is the "no tag" encoding.
    function automatic tag_t tag_inc(input tag_t t);
        tag_t n;
        n = t + tag_t'(1);
        if (n == '0) begin
            n = tag_t'(1);
        end
        return n;
    endfunction
endpackage

// File: rtl/rob_tag_inc.sv
// Combinational next-tag for the ROB head and tail pointers.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: tag_i current tag, tag_o next tag (skips 0 on wrap).
module rob_tag_inc
    import rob_pkg::*;
(
    input  tag_t tag_i,
    output tag_t tag_o
);
    assign tag_o = tag_inc(tag_i);
endmodule

// File: rtl/rob.sv
// Reorder buffer: in-order allocate, out-of-order CDB completion, in-order retire.
// Latency: alloc_tag/commit/lookup outputs combinational; state updates next edge.
// Backpressure: full refuses alloc_req (dropped); a non-ready head stalls retirement.
// Ports: clk/rst (sync, active-high); alloc_req/alloc_rd -> alloc_tag, full;
// CDB_ALU_ROB_index/CDB_ALU_data completion bus; qj/qk_tag -> *_ready/*_data lookups;
// commit_valid/commit_tag/commit_rd/commit_data retire port.
// Optional macro ROB_CDB_BYPASS_EN: lookups also see the same-cycle CDB broadcast.
module rob
    import rob_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_req,
    input  logic [REG_ADDR_W-1:0] alloc_rd,
    output logic [TAG_W-1:0]      alloc_tag,
    output logic                  full,
    input  logic [TAG_W-1:0]      CDB_ALU_ROB_index,
    input  logic [31:0]           CDB_ALU_data,
    input  logic [TAG_W-1:0]      qj_tag,
    input  logic [TAG_W-1:0]      qk_tag,
    output logic                  qj_ready,
    output logic                  qk_ready,
    output logic [31:0]           qj_data,
    output logic [31:0]           qk_data,
    output logic                  commit_valid,
    output logic [TAG_W-1:0]      commit_tag,
    output logic [REG_ADDR_W-1:0] commit_rd,
    output logic [31:0]           commit_data
);
    tag_t head_q, head_d, tail_q, tail_d, count_q, count_d;
    tag_t head_nxt, tail_nxt;

    logic [ROB_SLOTS-1:0]  busy_q, busy_d, ready_q, ready_d;
    logic [REG_ADDR_W-1:0] rd_q   [ROB_SLOTS];
    logic [REG_ADDR_W-1:0] rd_d   [ROB_SLOTS];
    logic [31:0]           data_q [ROB_SLOTS];
    logic [31:0]           data_d [ROB_SLOTS];

    logic full_int, alloc_ok, retire;

    rob_tag_inc u_head_inc (.tag_i(head_q), .tag_o(head_nxt));
    rob_tag_inc u_tail_inc (.tag_i(tail_q), .tag_o(tail_nxt));

    // Full is taken from the registered count, so a retire in the same cycle
    // does not open a slot until the next cycle.
    assign full_int = (count_q == tag_t'(ROB_DEPTH));
    assign alloc_ok = alloc_req && !full_int && !rst;
    assign retire   = (count_q != '0) && ready_q[head_q] && !rst;

    // Outputs are forced to their idle values while rst is high, since the
    // registers only clear at the edge.
    assign full         = full_int && !rst;
    assign alloc_tag    = rst ? tag_t'(1) : tail_q;
    assign commit_valid = retire;
    assign commit_tag   = retire ? head_q         : '0;
    assign commit_rd    = retire ? rd_q[head_q]   : '0;
    assign commit_data  = retire ? data_q[head_q] : '0;

    always_comb begin
        qj_ready = 1'b1;
        qj_data  = '0;
        qk_ready = 1'b1;
        qk_data  = '0;
        if (qj_tag != '0) begin
            qj_ready = ready_q[qj_tag];
            qj_data  = data_q[qj_tag];
        end
        if (qk_tag != '0) begin
            qk_ready = ready_q[qk_tag];
            qk_data  = data_q[qk_tag];
        end
`ifdef ROB_CDB_BYPASS_EN
        if (qj_tag != '0 && qj_tag == CDB_ALU_ROB_index) begin
            qj_ready = 1'b1;
            qj_data  = CDB_ALU_data;
        end
        if (qk_tag != '0 && qk_tag == CDB_ALU_ROB_index) begin
            qk_ready = 1'b1;
            qk_data  = CDB_ALU_data;
        end
`endif
    end

    always_comb begin
        busy_d  = busy_q;
        ready_d = ready_q;
        rd_d    = rd_q;
        data_d  = data_q;
        head_d  = retire   ? head_nxt : head_q;
        tail_d  = alloc_ok ? tail_nxt : tail_q;
        count_d = count_q;

        // Completion only lands on a live entry; stale tags are dropped.
        if (CDB_ALU_ROB_index != '0 && busy_q[CDB_ALU_ROB_index]) begin
            ready_d[CDB_ALU_ROB_index] = 1'b1;
            data_d[CDB_ALU_ROB_index]  = CDB_ALU_data;
        end

        // The tail slot is never busy when alloc is accepted, so this cannot
        // collide with the CDB write or the head clear below.
        if (alloc_ok) begin
            busy_d[tail_q]  = 1'b1;
            ready_d[tail_q] = 1'b0;
            rd_d[tail_q]    = alloc_rd;
            data_d[tail_q]  = '0;
        end

        if (retire) begin
            busy_d[head_q]  = 1'b0;
            ready_d[head_q] = 1'b0;
            rd_d[head_q]    = '0;
            data_d[head_q]  = '0;
        end

        case ({alloc_ok, retire})
            2'b10:   count_d = count_q + tag_t'(1);
            2'b01:   count_d = count_q - tag_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= tag_t'(1);
            tail_q  <= tag_t'(1);
            count_q <= '0;
            busy_q  <= '0;
            ready_q <= '0;
            for (int i = 0; i < ROB_SLOTS; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: tb/tb_rob.sv
module tb_rob;
    localparam int TW    = 3;
    localparam int RW    = 5;
    localparam int DEPTH = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_req;
    logic [RW-1:0] alloc_rd;
    logic [TW-1:0] alloc_tag;
    logic          full;
    logic [TW-1:0] cdb_idx;
    logic [31:0]   cdb_data;
    logic [TW-1:0] qj_tag, qk_tag;
    logic          qj_ready, qk_ready;
    logic [31:0]   qj_data, qk_data;
    logic          commit_valid;
    logic [TW-1:0] commit_tag;
    logic [RW-1:0] commit_rd;
    logic [31:0]   commit_data;

    always #5 clk = ~clk;

    rob #(.REG_ADDR_W(RW)) dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_rd(alloc_rd),
        .alloc_tag(alloc_tag), .full(full),
        .CDB_ALU_ROB_index(cdb_idx), .CDB_ALU_data(cdb_data),
        .qj_tag(qj_tag), .qk_tag(qk_tag),
        .qj_ready(qj_ready), .qk_ready(qk_ready),
        .qj_data(qj_data), .qk_data(qk_data),
        .commit_valid(commit_valid), .commit_tag(commit_tag),
        .commit_rd(commit_rd), .commit_data(commit_data)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the ROB is an ordered list of in-flight instructions, oldest first.
    typedef struct {
        int          tag;
        int          rd;
        bit          rdy;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    int          m_tail = 1;
    bit          m_on   = 0;
    bit          e_full, e_cv, e_r;
    logic [31:0] e_d;

    task automatic model_lookup(input int tag, output bit r, output logic [31:0] d);
        r = 1'b0;
        d = 32'h0;
        if (tag == 0) begin
            r = 1'b1;
        end else begin
            foreach (mq[i]) if (mq[i].tag == tag) begin
                r = mq[i].rdy;
                d = mq[i].data;
            end
        end
`ifdef ROB_CDB_BYPASS_EN
        if (tag != 0 && tag == int'(cdb_idx)) begin
            r = 1'b1;
            d = cdb_data;
        end
`endif
    endtask

    // Inputs change only at posedge+1, so the negedge sees what the next edge samples.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_alloc_tag", alloc_tag, 1);
            check("rst_full", full, 0);
            check("rst_commit_valid", commit_valid, 0);
            check("rst_commit_tag", commit_tag, 0);
            check("rst_commit_rd", commit_rd, 0);
            check("rst_commit_data", commit_data, 0);
            mq.delete();
            m_tail = 1;
            m_on   = 1'b1;
        end else if (m_on) begin
            e_full = (mq.size() == DEPTH);
            e_cv   = (mq.size() > 0) && mq[0].rdy;
            check("alloc_tag", alloc_tag, m_tail);
            check("full", full, e_full);
            check("commit_valid", commit_valid, e_cv);
            check("commit_tag", commit_tag, e_cv ? mq[0].tag : 0);
            check("commit_rd", commit_rd, e_cv ? mq[0].rd : 0);
            check("commit_data", commit_data, e_cv ? mq[0].data : 0);
            model_lookup(int'(qj_tag), e_r, e_d);
            check("qj_ready", qj_ready, e_r);
            check("qj_data", qj_data, e_d);
            model_lookup(int'(qk_tag), e_r, e_d);
            check("qk_ready", qk_ready, e_r);
            check("qk_data", qk_data, e_d);

            if (cdb_idx != 0) begin
                foreach (mq[i]) if (mq[i].tag == int'(cdb_idx)) begin
                    mq[i].rdy  = 1'b1;
                    mq[i].data = cdb_data;
                end
            end
            if (e_cv) void'(mq.pop_front());
            if (alloc_req && !e_full) begin
                mq.push_back('{tag: m_tail, rd: int'(alloc_rd), rdy: 1'b0, data: 32'h0});
                m_tail = (m_tail == DEPTH) ? 1 : m_tail + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req = 1'b0;
        alloc_rd  = '0;
        cdb_idx   = '0;
        cdb_data  = '0;
        qj_tag    = '0;
        qk_tag    = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("lit_after_rst_tag", alloc_tag, 1);
        check("lit_after_rst_full", full, 0);

        // Fill all seven entries, then try an eighth.
        for (int i = 1; i <= DEPTH; i++) begin
            alloc_req = 1'b1;
            alloc_rd  = RW'(i);
            #1;
            check("lit_fill_tag", alloc_tag, i);
            tick();
        end
        alloc_req = 1'b0;
        #1;
        check("lit_full_after7", full, 1);
        check("lit_tail_wrap", alloc_tag, 1);
        alloc_req = 1'b1;
        alloc_rd  = 5'd20;
        tick();
        alloc_req = 1'b0;
        #1;
        check("lit_8th_dropped_full", full, 1);
        check("lit_8th_dropped_tag", alloc_tag, 1);

        // Full with ready head: alloc in retiring cycle is refused.
        cdb_idx  = 3'd1;
        cdb_data = 32'h11;
        tick();
        cdb_idx   = '0;
        alloc_req = 1'b1;
        alloc_rd  = 5'd9;
        #1;
        check("lit_wrap_cv", commit_valid, 1);
        check("lit_wrap_full", full, 1);
        check("lit_wrap_cdata", commit_data, 32'h11);
        tick();
        #1;
        check("lit_wrap_tag1", alloc_tag, 1);
        check("lit_wrap_notfull", full, 0);
        tick();
        alloc_req = 1'b0;
        #1;
        check("lit_wrap_full_again", full, 1);

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Single alloc, completion on the head, retire one cycle later.
        alloc_req = 1'b1;
        alloc_rd  = 5'd5;
        tick();
        alloc_req = 1'b0;
        cdb_idx   = 3'd1;
        cdb_data  = 32'd101;
        #1;
        check("lit_cdb_head_not_yet", commit_valid, 0);
        tick();
        cdb_idx = '0;
        #1;
        check("lit_commit_valid", commit_valid, 1);
        check("lit_commit_rd", commit_rd, 5);
        check("lit_commit_data", commit_data, 101);
        check("lit_commit_tag", commit_tag, 1);
        tick();
        check("lit_drained_cv", commit_valid, 0);
        check("lit_drained_tag", alloc_tag, 2);

        // Younger entry completes first; head blocks it.
        alloc_req = 1'b1;
        alloc_rd  = 5'd3;
        tick();
        alloc_rd  = 5'd4;
        tick();
        alloc_req = 1'b0;
        cdb_idx   = 3'd3;
        cdb_data  = 32'd7;
        tick();
        cdb_idx = '0;
        tick();
        check("lit_blocked_cv", commit_valid, 0);
        cdb_idx  = 3'd2;
        cdb_data = 32'd3;
        tick();
        cdb_idx = '0;
        #1;
        check("lit_inorder_first", commit_tag, 2);
        check("lit_inorder_first_d", commit_data, 3);
        tick();
        check("lit_inorder_second", commit_tag, 3);
        check("lit_inorder_second_d", commit_data, 7);
        tick();
        check("lit_inorder_done", commit_valid, 0);

        // Lookup against a same-cycle broadcast; qk on tag 0.
        alloc_req = 1'b1;
        alloc_rd  = 5'd1;
        tick();
        alloc_req = 1'b0;
        cdb_idx   = 3'd4;
        cdb_data  = 32'hAA;
        qj_tag    = 3'd4;
        qk_tag    = 3'd0;
        #1;
`ifdef ROB_CDB_BYPASS_EN
        check("lit_bypass_qj_ready", qj_ready, 1);
        check("lit_bypass_qj_data", qj_data, 32'hAA);
`else
        check("lit_nobypass_qj_ready", qj_ready, 0);
`endif
        check("lit_qk0_ready", qk_ready, 1);
        check("lit_qk0_data", qk_data, 0);
        tick();
        cdb_idx = '0;
        #1;
        check("lit_reg_qj_ready", qj_ready, 1);
        check("lit_reg_qj_data", qj_data, 32'hAA);
        tick();
        idle();

        // Three in flight, then reset while alloc and CDB are active.
        alloc_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alloc_rd = RW'(10 + i);
            tick();
        end
        cdb_idx  = 3'd5;
        cdb_data = 32'h55;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        #1;
        check("lit_midrst_cv", commit_valid, 0);
        check("lit_midrst_full", full, 0);
        check("lit_midrst_tag", alloc_tag, 1);
        alloc_req = 1'b1;
        alloc_rd  = 5'd2;
        tick();
        alloc_req = 1'b0;
        #1;
        check("lit_midrst_next_tag", alloc_tag, 2);

        // Mixed traffic, checked cycle by cycle by the model.
        for (int c = 0; c < 400; c++) begin
            alloc_req = ($urandom_range(0, 9) < 6);
            alloc_rd  = RW'($urandom_range(0, 31));
            cdb_idx   = TW'($urandom_range(0, 7));
            cdb_data  = $urandom;
            qj_tag    = TW'($urandom_range(0, 7));
            qk_tag    = TW'($urandom_range(0, 7));
            tick();
        end
        idle();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
